// File: rtl/debounce_pkg.sv
// Shared constants, hold-phase encoding and a width helper for the debouncer family.
package debounce_pkg;

  localparam int DB_PSC_10MHZ_25MS = 250000;
  localparam int DB_SAMPLES_DEF    = 3;
  localparam int DB_LONG_DEF       = 40;
  localparam int DB_REPEAT_DEF     = 8;

  typedef enum logic {
    HOLD_LONG   = 1'b0,
    HOLD_REPEAT = 1'b1
  } hold_phase_t;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int db_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: 2-FF synchroniser, disagree counter, debounced level,
// hold counter with long-press/auto-repeat, and registered edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SAMPLES      = DB_SAMPLES_DEF,
  parameter int LONG_TICKS   = DB_LONG_DEF,
  parameter int REPEAT_TICKS = DB_REPEAT_DEF,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int DCW = db_width(SAMPLES - 1);
  localparam int HCW = db_width((LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS);
  localparam logic [DCW-1:0] DC_LAST   = DCW'(SAMPLES - 1);
  localparam logic [HCW-1:0] HC_LONG   = HCW'(LONG_TICKS);
  localparam logic [HCW-1:0] HC_REPEAT = HCW'(REPEAT_TICKS);
  localparam logic INVERT = (ACTIVE_LOW != 0);

  logic [1:0]     sync_q;
  logic           s;
  logic [DCW-1:0] dc_q, dc_d;
  logic           level_d;
  logic [HCW-1:0] hc_q, hc_d, hc_inc;
  hold_phase_t    phase_q, phase_d;
  logic           rise_d, fall_d, lp_d;
  logic           accept;

  assign s      = sync_q[1] ^ INVERT;
  assign hc_inc = hc_q + 1'b1;
  assign accept = (s != level) && (dc_q == DC_LAST);

  always_comb begin
    dc_d    = dc_q;
    level_d = level;
    hc_d    = hc_q;
    phase_d = phase_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    lp_d    = 1'b0;
    if (en && tick) begin
      if (s == level) begin
        dc_d = '0;
      end else if (accept) begin
        level_d = s;
        dc_d    = '0;
        rise_d  = s;
        fall_d  = ~s;
      end else begin
        dc_d = dc_q + 1'b1;
      end

      // An accepted sample while level is high is the fall, which drops any hold progress.
      if (!level || accept) begin
        hc_d    = '0;
        phase_d = HOLD_LONG;
      end else if (phase_q == HOLD_REPEAT) begin
        if (hc_inc == HC_REPEAT) begin
          lp_d = 1'b1;
          hc_d = '0;
        end else begin
          hc_d = hc_inc;
        end
      end else if (hc_q == HC_LONG) begin
        hc_d = hc_q;
      end else if (hc_inc == HC_LONG) begin
        lp_d = 1'b1;
        if (REPEAT_TICKS > 0) begin
          hc_d    = '0;
          phase_d = HOLD_REPEAT;
        end else begin
          hc_d = HC_LONG;
        end
      end else begin
        hc_d = hc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      dc_q       <= '0;
      level      <= 1'b0;
      hc_q       <= '0;
      phase_q    <= HOLD_LONG;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], raw};
      dc_q       <= dc_d;
      level      <= level_d;
      hc_q       <= hc_d;
      phase_q    <= phase_d;
      rise       <= rise_d;
      fall       <= fall_d;
      long_press <= lp_d;
    end
  end

endmodule

// File: rtl/debouncer_nch.sv
// N-channel switch debouncer: shared sample-tick prescaler feeding one
// debounce_channel per input.
module debouncer_nch
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int PSC_CYCLES   = DB_PSC_10MHZ_25MS,
  parameter int SAMPLES      = DB_SAMPLES_DEF,
  parameter int LONG_TICKS   = DB_LONG_DEF,
  parameter int REPEAT_TICKS = DB_REPEAT_DEF,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press,
  output logic            tick
);

  localparam int PW = $clog2(PSC_CYCLES);
  localparam logic [PW-1:0] PSC_LAST = PW'(PSC_CYCLES - 1);

  logic [PW-1:0] psc_q, psc_d;

  // Disabling parks the prescaler at 0, so tick cannot sit high while frozen.
  always_comb begin
    psc_d = psc_q + 1'b1;
    if (!en || (psc_q == PSC_LAST)) begin
      psc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
      tick  <= 1'b0;
    end else begin
      psc_q <= psc_d;
      tick  <= (psc_d == PSC_LAST);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SAMPLES      (SAMPLES),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .tick       (tick),
      .raw        (raw_in[i]),
      .level      (level[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .long_press (long_press[i])
    );
  end

endmodule

// File: tb/tb_debouncer_nch.sv
// Scoreboard bench for debouncer_nch: an active-high and an active-low build
// checked cycle by cycle against a tick-level reference, plus directed checks.
module tb_debouncer_nch;

  localparam int PSC  = 4;
  localparam int SAMP = 3;
  localparam int LONG = 5;
  localparam int REP  = 2;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       en    = 1'b1;
  logic [3:0] raw_a = 4'hF;
  logic [3:0] raw_b = 4'h0;
  logic [3:0] level_a, rise_a, fall_a, lp_a;
  logic [3:0] level_b, rise_b, fall_b, lp_b;
  logic       tick_a, tick_b;

  int check_count = 0;
  int pass_count  = 0;

  typedef logic [16:0] snap_t;
  snap_t exp_a[$];
  snap_t exp_b[$];

  logic       model_live = 1'b0;
  int         cyc = 0;
  int         psc = 0;
  logic [3:0] m_s1[2], m_s2[2], m_level[2], m_rise[2], m_fall[2], m_lp[2];
  int         m_dis[2][4];
  int         m_held[2][4];

  int rise_cnt_a[4], fall_cnt_a[4], rise_cyc_a[4], fall_cyc_a[4];
  int rise_cnt_b[4], rise_cyc_b[4];
  int lp_cyc2[$];
  int rel_cyc;

  always #5 clk = ~clk;

  debouncer_nch #(
    .N_CH(4), .PSC_CYCLES(PSC), .SAMPLES(SAMP),
    .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_a),
    .level(level_a), .rise(rise_a), .fall(fall_a), .long_press(lp_a), .tick(tick_a)
  );

  debouncer_nch #(
    .N_CH(4), .PSC_CYCLES(PSC), .SAMPLES(SAMP),
    .LONG_TICKS(LONG), .REPEAT_TICKS(REP), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .raw_in(raw_b),
    .level(level_b), .rise(rise_b), .fall(fall_b), .long_press(lp_b), .tick(tick_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      pass_count++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ra, input logic [3:0] rb, input logic e, input int cycles);
    raw_a = ra;
    raw_b = rb;
    en    = e;
    repeat (cycles) @(negedge clk);
  endtask

  // Reference: counts consecutive disagreeing ticks and total held ticks since the rise.
  task automatic modelStep();
    logic tick_now, s, flip;
    cyc++;
    if (rst) begin
      model_live = 1'b1;
      psc = 0;
      for (int d = 0; d < 2; d++) begin
        m_s1[d] = '0; m_s2[d] = '0; m_level[d] = '0;
        m_rise[d] = '0; m_fall[d] = '0; m_lp[d] = '0;
        for (int c = 0; c < 4; c++) begin
          m_dis[d][c]  = 0;
          m_held[d][c] = 0;
        end
      end
    end else begin
      tick_now = (psc == PSC - 1);
      if (!en || tick_now) psc = 0;
      else psc++;
      for (int d = 0; d < 2; d++) begin
        m_rise[d] = '0; m_fall[d] = '0; m_lp[d] = '0;
        for (int c = 0; c < 4; c++) begin
          s = m_s2[d][c] ^ (d == 1);
          if (en && tick_now) begin
            flip = 1'b0;
            if (s != m_level[d][c]) begin
              m_dis[d][c]++;
              flip = (m_dis[d][c] == SAMP);
            end else begin
              m_dis[d][c] = 0;
            end
            if (m_level[d][c] && !flip) begin
              m_held[d][c]++;
              if (m_held[d][c] == LONG ||
                  (REP > 0 && m_held[d][c] > LONG && (m_held[d][c] - LONG) % REP == 0))
                m_lp[d][c] = 1'b1;
            end else begin
              m_held[d][c] = 0;
            end
            if (flip) begin
              m_level[d][c] = s;
              m_dis[d][c]   = 0;
              m_rise[d][c]  = s;
              m_fall[d][c]  = ~s;
            end
          end
        end
        m_s2[d] = m_s1[d];
        m_s1[d] = (d == 0) ? raw_a : raw_b;
      end
    end
    if (model_live) begin
      exp_a.push_back({m_level[0], m_rise[0], m_fall[0], m_lp[0], psc == PSC - 1});
      exp_b.push_back({m_level[1], m_rise[1], m_fall[1], m_lp[1], psc == PSC - 1});
    end
  endtask

  always @(posedge clk) modelStep();

  always @(negedge clk) begin
    if (model_live && exp_a.size() > 0 && exp_b.size() > 0) begin
      checkOutput("cycle_a", {15'd0, level_a, rise_a, fall_a, lp_a, tick_a}, {15'd0, exp_a.pop_front()});
      checkOutput("cycle_b", {15'd0, level_b, rise_b, fall_b, lp_b, tick_b}, {15'd0, exp_b.pop_front()});
    end
    for (int c = 0; c < 4; c++) begin
      if (rise_a[c]) begin rise_cnt_a[c]++; rise_cyc_a[c] = cyc; end
      if (fall_a[c]) begin fall_cnt_a[c]++; fall_cyc_a[c] = cyc; end
      if (rise_b[c]) begin rise_cnt_b[c]++; rise_cyc_b[c] = cyc; end
    end
    if (lp_a[2]) lp_cyc2.push_back(cyc);
  end

  initial begin
    int         k;
    logic [3:0] cur;
    logic [3:0] lvl0;
    logic       any_tick, any_pulse, any_change;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Mid-debounce reset with inputs active
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_a", {level_a, rise_a, fall_a, lp_a, tick_a}, 0);
    checkOutput("reset_b", {level_b, rise_b, fall_b, lp_b, tick_b}, 0);
    checkOutput("reset_no_rise_b", rise_cnt_b[0], 0);
    rst = 1'b0;
    rel_cyc = cyc;
    k = 0;
    while (!tick_a && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("first_tick", k, 3);

    applyStimulus(4'h0, 4'h0, 1'b1, 24);
    checkOutput("al_level", level_b, 4'hF);
    checkOutput("al_rise_cycle", rise_cyc_b[0] - rel_cyc, 12);
    checkOutput("al_rise_count", rise_cnt_b[0], 1);

    // Clean press on ch0
    applyStimulus(4'h1, 4'h0, 1'b1, 24);
    checkOutput("press_level", level_a, 4'h1);
    checkOutput("press_rise", rise_cnt_a[0], 1);
    checkOutput("press_fall", fall_cnt_a[0], 0);

    // Bounce on ch1, then settle high
    cur = 4'h1;
    for (int i = 0; i < 13; i++) begin
      cur[1] = ~cur[1];
      applyStimulus(cur, 4'h0, 1'b1, 3);
    end
    checkOutput("bounce_level", level_a[1], 0);
    checkOutput("bounce_edges", rise_cnt_a[1] + fall_cnt_a[1], 0);
    applyStimulus(4'h3, 4'h0, 1'b1, 20);
    checkOutput("settle_level", level_a[1], 1);
    checkOutput("settle_rise", rise_cnt_a[1], 1);

    // Long press and repeat on ch2
    applyStimulus(4'h7, 4'h0, 1'b1, 60);
    checkOutput("lp_count_min", lp_cyc2.size() >= 3, 1);
    if (lp_cyc2.size() >= 3) begin
      checkOutput("lp_first", lp_cyc2[0] - rise_cyc_a[2], 20);
      checkOutput("lp_repeat1", lp_cyc2[1] - lp_cyc2[0], 8);
      checkOutput("lp_repeat2", lp_cyc2[2] - lp_cyc2[1], 8);
    end
    applyStimulus(4'h3, 4'h0, 1'b1, 30);
    checkOutput("release_fall", fall_cnt_a[2], 1);
    checkOutput("release_level", level_a[2], 0);
    checkOutput("no_lp_after_fall",
                lp_cyc2.size() > 0 && lp_cyc2[lp_cyc2.size() - 1] > fall_cyc_a[2], 0);

    // Enable freeze during ch3 debounce
    applyStimulus(4'hB, 4'h0, 1'b1, 6);
    lvl0       = level_a;
    any_tick   = 1'b0;
    any_pulse  = 1'b0;
    any_change = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_tick   |= tick_a | tick_b;
      any_pulse  |= |(rise_a | fall_a | lp_a | rise_b | fall_b | lp_b);
      any_change |= (level_a != lvl0);
    end
    checkOutput("freeze_tick", any_tick, 0);
    checkOutput("freeze_pulse", any_pulse, 0);
    checkOutput("freeze_level", any_change, 0);
    applyStimulus(4'hB, 4'h0, 1'b1, 30);
    checkOutput("resume_level", level_a[3], 1);
    checkOutput("resume_rise", rise_cnt_a[3], 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
